// File: rtl/move_pulse_gen.sv
// Movement button front-end: synchronise, debounce, prioritise and emit
// single-cycle command pulses with auto-repeat for movement_control.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | waiting for any debounced button; latches highest-priority cmd
// FIRE  | one cycle with the cmd pulse and is_pulse high
// GAP   | GAP_CYCLES forced idle cycles so the consumer can settle
// HOLD  | cmd button still held; counts towards the next auto-repeat
module move_pulse_gen #(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
    parameter logic [3:0]  GAP_CYCLES      = 4'd2,
    parameter logic [23:0] REPEAT_DELAY    = 24'd6500000,
    parameter logic [23:0] REPEAT_PERIOD   = 24'd3250000
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic btn_fwd_in,
    input  logic btn_bwd_in,
    input  logic btn_left_in,
    input  logic btn_right_in,
    output logic fwd_pulse,
    output logic bwd_pulse,
    output logic leftRot_pulse,
    output logic rightRot_pulse,
    output logic is_pulse
);

    typedef enum logic [1:0] {S_IDLE, S_FIRE, S_GAP, S_HOLD} state_t;

    // Bit positions double as command codes, in priority order.
    localparam logic [1:0] CMD_FWD   = 2'd0;
    localparam logic [1:0] CMD_BWD   = 2'd1;
    localparam logic [1:0] CMD_LEFT  = 2'd2;
    localparam logic [1:0] CMD_RIGHT = 2'd3;

    logic [3:0] btn_raw;
    logic [3:0] sync_a;
    logic [3:0] sync_b;
    logic [3:0] stable;

    assign btn_raw = {btn_right_in, btn_left_in, btn_bwd_in, btn_fwd_in};

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            sync_a <= '0;
            sync_b <= '0;
        end else begin
            sync_a <= btn_raw;
            sync_b <= sync_a;
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_deb
        logic [15:0] deb_cnt;
        logic        stable_bit;

        always_ff @(posedge clk_in or negedge rst_in) begin
            if (!rst_in) begin
                deb_cnt    <= '0;
                stable_bit <= 1'b0;
            end else if (sync_b[g] == stable_bit) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DEBOUNCE_CYCLES - 16'd1) begin
                stable_bit <= sync_b[g];
                deb_cnt    <= '0;
            end else begin
                deb_cnt <= deb_cnt + 16'd1;
            end
        end

        assign stable[g] = stable_bit;
    end

    state_t      state_q, state_d;
    logic [1:0]  cmd_q, cmd_d;
    logic        first_q, first_d;
    logic [3:0]  gap_q, gap_d;
    logic [23:0] rpt_q, rpt_d;
    logic [3:0]  pulse_q, pulse_d;
    logic        is_q, is_d;

    logic [1:0]  pick_cmd;
    logic        cmd_held;
    logic [23:0] rpt_thresh;

    always_comb begin
        pick_cmd = CMD_FWD;
        if (stable[CMD_FWD])        pick_cmd = CMD_FWD;
        else if (stable[CMD_BWD])   pick_cmd = CMD_BWD;
        else if (stable[CMD_LEFT])  pick_cmd = CMD_LEFT;
        else if (stable[CMD_RIGHT]) pick_cmd = CMD_RIGHT;
    end

    assign cmd_held   = stable[cmd_q];
    assign rpt_thresh = first_q ? REPEAT_DELAY : REPEAT_PERIOD;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q <= S_IDLE;
            cmd_q   <= CMD_FWD;
            first_q <= 1'b0;
            gap_q   <= '0;
            rpt_q   <= '0;
            pulse_q <= '0;
            is_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            first_q <= first_d;
            gap_q   <= gap_d;
            rpt_q   <= rpt_d;
            pulse_q <= pulse_d;
            is_q    <= is_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        first_d = first_q;
        gap_d   = gap_q;
        rpt_d   = rpt_q;
        case (state_q)
            S_IDLE: begin
                if (|stable) begin
                    cmd_d   = pick_cmd;
                    first_d = 1'b1;
                    state_d = S_FIRE;
                end
            end
            S_FIRE: begin
                gap_d   = '0;
                state_d = S_GAP;
            end
            S_GAP: begin
                if (gap_q == GAP_CYCLES - 4'd1) begin
                    rpt_d   = '0;
                    state_d = S_HOLD;
                end else begin
                    gap_d = gap_q + 4'd1;
                end
            end
            S_HOLD: begin
                // A zero REPEAT_DELAY parks here until release.
                if (!cmd_held) begin
                    state_d = S_IDLE;
                end else if (REPEAT_DELAY != 24'd0) begin
                    if (rpt_q == rpt_thresh - 24'd1) begin
                        first_d = 1'b0;
                        state_d = S_FIRE;
                    end else begin
                        rpt_d = rpt_q + 24'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are computed from the next state so they come straight from flops.
    always_comb begin
        pulse_d = '0;
        is_d    = 1'b0;
        if (state_d == S_FIRE) begin
            pulse_d[cmd_d] = 1'b1;
            is_d           = 1'b1;
        end
    end

    assign fwd_pulse      = pulse_q[CMD_FWD];
    assign bwd_pulse      = pulse_q[CMD_BWD];
    assign leftRot_pulse  = pulse_q[CMD_LEFT];
    assign rightRot_pulse = pulse_q[CMD_RIGHT];
    assign is_pulse       = is_q;

endmodule

// File: tb/tb_move_pulse_gen.sv
// Directed bench for move_pulse_gen; a second instance has auto-repeat disabled.
module tb_move_pulse_gen;

    logic clk_in = 1'b0;
    logic rst_in;
    logic btn_fwd_in, btn_bwd_in, btn_left_in, btn_right_in;
    logic fwd_pulse, bwd_pulse, leftRot_pulse, rightRot_pulse, is_pulse;
    logic nr_fwd, nr_bwd, nr_left, nr_right, nr_is;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int nr_cnt = 0;
    int t0, r0, found;
    int pcyc[$];
    int pid[$];

    move_pulse_gen #(
        .DEBOUNCE_CYCLES(16'd4), .GAP_CYCLES(4'd2),
        .REPEAT_DELAY(24'd10), .REPEAT_PERIOD(24'd5)
    ) u_dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .btn_fwd_in(btn_fwd_in), .btn_bwd_in(btn_bwd_in),
        .btn_left_in(btn_left_in), .btn_right_in(btn_right_in),
        .fwd_pulse(fwd_pulse), .bwd_pulse(bwd_pulse),
        .leftRot_pulse(leftRot_pulse), .rightRot_pulse(rightRot_pulse),
        .is_pulse(is_pulse)
    );

    move_pulse_gen #(
        .DEBOUNCE_CYCLES(16'd4), .GAP_CYCLES(4'd2),
        .REPEAT_DELAY(24'd0), .REPEAT_PERIOD(24'd5)
    ) u_norep (
        .clk_in(clk_in), .rst_in(rst_in),
        .btn_fwd_in(btn_fwd_in), .btn_bwd_in(btn_bwd_in),
        .btn_left_in(btn_left_in), .btn_right_in(btn_right_in),
        .fwd_pulse(nr_fwd), .bwd_pulse(nr_bwd),
        .leftRot_pulse(nr_left), .rightRot_pulse(nr_right),
        .is_pulse(nr_is)
    );

    always #5 clk_in = ~clk_in;
    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int qcyc(input int k);
        return (k < pcyc.size()) ? pcyc[k] : -1;
    endfunction

    function automatic int qid(input int k);
        return (k < pid.size()) ? pid[k] : -1;
    endfunction

    // Per-cycle consistency checks plus a log of every pulse seen.
    task automatic sample();
        logic [3:0] pv;
        pv = {rightRot_pulse, leftRot_pulse, bwd_pulse, fwd_pulse};
        chk("is_pulse_match", int'(is_pulse), int'(pv != 4'd0));
        chk("pulse_onehot", ($countones(pv) > 1) ? 1 : 0, 0);
        if (pv != 4'd0) begin
            pcyc.push_back(cyc);
            pid.push_back(pv[0] ? 0 : pv[1] ? 1 : pv[2] ? 2 : 3);
        end
        if (nr_fwd) nr_cnt++;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk_in);
            sample();
        end
    endtask

    task automatic clear_log();
        pcyc.delete();
        pid.delete();
    endtask

    initial begin
        rst_in = 1'b0;
        btn_fwd_in = 1'b0; btn_bwd_in = 1'b0;
        btn_left_in = 1'b0; btn_right_in = 1'b0;
        step(3);
        chk("reset_outputs", int'({fwd_pulse, bwd_pulse, leftRot_pulse, rightRot_pulse, is_pulse}), 0);
        chk("reset_outputs_norep", int'({nr_fwd, nr_bwd, nr_left, nr_right, nr_is}), 0);
        rst_in = 1'b1;
        step(5);

        // Single press of 8 cycles
        clear_log(); t0 = cyc;
        btn_fwd_in = 1'b1; step(8);
        btn_fwd_in = 1'b0; step(30);
        chk("single_count", pcyc.size(), 1);
        chk("single_id", qid(0), 0);
        chk("single_latency", qcyc(0) - t0, 7);

        // Bounce shorter than the debounce window
        clear_log();
        for (int i = 0; i < 5; i++) begin
            btn_left_in = 1'b1; step(2);
            btn_left_in = 1'b0; step(2);
        end
        step(10);
        chk("bounce_count", pcyc.size(), 0);

        // Held left: initial pulse, then first and later repeats
        clear_log(); t0 = cyc;
        btn_left_in = 1'b1; step(26);
        btn_left_in = 1'b0; step(30);
        chk("hold_count", pcyc.size(), 3);
        chk("hold_id", qid(0) + qid(1) + qid(2), 6);
        chk("hold_first", qcyc(0) - t0, 7);
        chk("hold_rep1", qcyc(1) - qcyc(0), 13);
        chk("hold_rep2", qcyc(2) - qcyc(0), 21);

        // Simultaneous bwd+right: bwd wins, right follows bwd release
        clear_log(); t0 = cyc;
        btn_bwd_in = 1'b1; btn_right_in = 1'b1; step(10);
        btn_bwd_in = 1'b0; step(40);
        btn_right_in = 1'b0; step(20);
        chk("simul_count", pcyc.size(), 6);
        chk("simul_first_id", qid(0), 1);
        chk("simul_first_cyc", qcyc(0) - t0, 7);
        chk("simul_right_id", qid(1), 3);
        chk("simul_right_after_fall", qcyc(1) - (t0 + 10), 8);
        chk("simul_last_cyc", qcyc(5) - t0, 55);

        // Latched right ignores fwd until right is released
        clear_log(); t0 = cyc;
        btn_right_in = 1'b1; step(12);
        btn_fwd_in = 1'b1; step(28);
        btn_right_in = 1'b0; step(12);
        btn_fwd_in = 1'b0; step(30);
        chk("latch_count", pcyc.size(), 6);
        chk("latch_right_ids", qid(0) + qid(1) + qid(2) + qid(3) + qid(4), 15);
        chk("latch_r0", qcyc(0) - t0, 7);
        chk("latch_r1", qcyc(1) - qcyc(0), 13);
        chk("latch_r2", qcyc(2) - qcyc(1), 8);
        chk("latch_r4", qcyc(4) - t0, 44);
        chk("latch_fwd_id", qid(5), 0);
        chk("latch_fwd_cyc", qcyc(5) - t0, 49);

        // Reset asserted in the FIRE cycle
        clear_log(); t0 = cyc;
        btn_right_in = 1'b1;
        found = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            step(1);
            if (rightRot_pulse) found = 1;
        end
        chk("rst_fire_seen", found, 1);
        rst_in = 1'b0;
        #1;
        chk("rst_async_drop", int'({fwd_pulse, bwd_pulse, leftRot_pulse, rightRot_pulse, is_pulse}), 0);
        step(2);
        rst_in = 1'b1;
        clear_log(); r0 = cyc;
        step(12);
        chk("rst_fresh_count", pcyc.size(), 1);
        chk("rst_fresh_id", qid(0), 3);
        chk("rst_fresh_latency", qcyc(0) - r0, 7);
        btn_right_in = 1'b0; step(20);

        // Auto-repeat disabled instance vs repeating instance
        clear_log(); nr_cnt = 0; t0 = cyc;
        btn_fwd_in = 1'b1; step(50);
        btn_fwd_in = 1'b0; step(20);
        chk("norep_count", nr_cnt, 1);
        chk("rep_count", pcyc.size(), 6);
        chk("rep_last", qcyc(5) - t0, 52);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
